// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared types and helpers for the data-memory controller
// Rev 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        RMW_WR = 2'd2
    } dmem_state_t;

    localparam int PORT_LSU = 0;
    localparam int PORT_DBG = 1;

    // Byte k of the result comes from new_w when be[k] is set, else from old_w.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-input round-robin arbiter, combinational grant
// Rev 1.0
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the most recently granted port; favours port 0 after reset.
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_ctrl : two-port data-memory controller with post-reset clear and
//             read-modify-write sub-word stores
// Rev 1.0
// ============================================================================
module dmem_ctrl #(
    parameter int P_CLR_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_we,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    input  logic [3:0]  i_be0,
    input  logic [3:0]  i_be1,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_rvalid,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_A,
    output logic [31:0] o_mem_WD,
    output logic        o_mem_WE,
    input  logic [31:0] i_mem_RD,
    output logic        o_init_done
);
    import dmem_pkg::*;

    localparam int             CW       = (P_CLR_WORDS > 1) ? $clog2(P_CLR_WORDS) : 1;
    localparam logic [CW-1:0]  CLR_LAST = CW'(P_CLR_WORDS - 1);

    dmem_state_t   state;
    logic [CW-1:0] clr_idx;
    logic [1:0]    gnt;

    logic          sel_we;
    logic [29:0]   sel_word;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;
    logic          sel_partial;

    logic [29:0]   rmw_word;
    logic [31:0]   rmw_wdata;
    logic [31:0]   rmw_old;
    logic [3:0]    rmw_be;

    // Byte offsets are dropped: the array is word addressed.
    logic          unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr0[1:0], i_addr1[1:0]};

    rr_arb2 u_arb (
        .clk (i_clk),
        .rst (i_rst),
        .en  (state == IDLE),
        .req (i_req),
        .gnt (gnt)
    );

    assign o_gnt = gnt;

    assign sel_we      = gnt[PORT_DBG] ? i_we[PORT_DBG]  : i_we[PORT_LSU];
    assign sel_word    = gnt[PORT_DBG] ? i_addr1[31:2]   : i_addr0[31:2];
    assign sel_wdata   = gnt[PORT_DBG] ? i_wdata1        : i_wdata0;
    assign sel_be      = gnt[PORT_DBG] ? i_be1           : i_be0;
    assign sel_partial = (sel_be != 4'hF) && (sel_be != 4'h0);

    // Array drive; forced idle while reset is asserted so a pending RMW
    // write cannot land.
    always_comb begin
        o_mem_A  = 32'd0;
        o_mem_WD = 32'd0;
        o_mem_WE = 1'b0;
        case (state)
            CLEAR: begin
                o_mem_A  = {30'(clr_idx), 2'b00};
                o_mem_WE = 1'b1;
            end
            IDLE: begin
                if (|gnt) begin
                    o_mem_A = {sel_word, 2'b00};
                    if (sel_we && (sel_be == 4'hF)) begin
                        o_mem_WE = 1'b1;
                        o_mem_WD = sel_wdata;
                    end
                end
            end
            RMW_WR: begin
                o_mem_A  = {rmw_word, 2'b00};
                o_mem_WD = be_merge(rmw_old, rmw_wdata, rmw_be);
                o_mem_WE = 1'b1;
            end
            default: ;
        endcase
        if (i_rst) begin
            o_mem_A  = 32'd0;
            o_mem_WD = 32'd0;
            o_mem_WE = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= CLEAR;
            clr_idx     <= '0;
            o_init_done <= 1'b0;
            o_rvalid    <= 2'b00;
            o_rdata     <= 32'd0;
            rmw_word    <= 30'd0;
            rmw_wdata   <= 32'd0;
            rmw_old     <= 32'd0;
            rmw_be      <= 4'h0;
        end else begin
            o_rvalid <= 2'b00;
            case (state)
                CLEAR: begin
                    if (clr_idx == CLR_LAST) begin
                        clr_idx     <= '0;
                        state       <= IDLE;
                        o_init_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                IDLE: begin
                    if (|gnt) begin
                        if (!sel_we) begin
                            o_rdata  <= i_mem_RD;
                            o_rvalid <= gnt;
                        end else if (sel_partial) begin
                            rmw_word  <= sel_word;
                            rmw_wdata <= sel_wdata;
                            rmw_be    <= sel_be;
                            rmw_old   <= i_mem_RD;
                            state     <= RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_ctrl : self-checking bench for dmem_ctrl with a behavioural array
// Rev 1.0
// ============================================================================
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        mem_we, init_done;

    logic [31:0] mem [0:63];
    logic        fill_en = 1'b0;
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'd0;

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_port[$];
    logic [31:0] exp_data[$];

    always #5 clk = ~clk;

    dmem_ctrl #(.P_CLR_WORDS(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_we        (we),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_wdata0    (wdata0),
        .i_wdata1    (wdata1),
        .i_be0       (be0),
        .i_be1       (be1),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_mem_A     (mem_a),
        .o_mem_WD    (mem_wd),
        .o_mem_WE    (mem_we),
        .i_mem_RD    (mem_rd),
        .o_init_done (init_done)
    );

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
        if (poke_en) mem[poke_idx] <= poke_val;
    end

    // Read-data scoreboard: every rvalid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rvalid !== 2'b00) begin
            vectors++;
            if (exp_data.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: rvalid=%b rdata=%h, expected no read response", rvalid, rdata);
            end else begin
                int          p;
                logic [31:0] d;
                p = exp_port.pop_front();
                d = exp_data.pop_front();
                if (rvalid !== (2'b01 << p) || rdata !== d) begin
                    miscompares++;
                    $display("FAIL rd_data: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                             rvalid, rdata, 2'b01 << p, d);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fill_en = 1'b1;
        req = 2'b11; we = 2'b00;
        addr0 = 32'h0; addr1 = 32'h4;
        wdata0 = 32'h0; wdata1 = 32'h0; be0 = 4'hF; be1 = 4'hF;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b00 || rvalid !== 2'b00 || rdata !== 32'h0 || init_done !== 1'b0 ||
            mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_vals: gnt=%b rvalid=%b rdata=%h done=%b we=%b A=%h WD=%h, expected all zero",
                     gnt, rvalid, rdata, init_done, mem_we, mem_a, mem_wd);
        end
        next_cycle();
        rst = 1'b0; fill_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_we !== 1'b1 || mem_a !== 32'(k * 4) || mem_wd !== 32'h0 || gnt !== 2'b00 || init_done !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_cycle%0d: we=%b A=%h WD=%h gnt=%b done=%b, expected we=1 A=%h WD=0 gnt=00 done=0",
                         k, mem_we, mem_a, mem_wd, gnt, init_done, k * 4);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (init_done !== 1'b1 || gnt !== 2'b01) begin
            miscompares++;
            $display("FAIL clear_done: done=%b gnt=%b, expected done=1 gnt=01", init_done, gnt);
        end
        exp_port.push_back(0); exp_data.push_back(32'h0);
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        vectors++;
        if (mem[0] !== 32'h0 || mem[3] !== 32'h0 || mem[4] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL clear_region: mem[0]=%h mem[3]=%h mem[4]=%h, expected 0 0 ffffffff", mem[0], mem[3], mem[4]);
        end
        next_cycle();
    endtask

    task automatic test_full_write_read();
        req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'hDEAD_BEEF; be0 = 4'hF;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b01 || mem_we !== 1'b1 || mem_a !== 32'h20 || mem_wd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL full_wr: gnt=%b we=%b A=%h WD=%h, expected 01 1 00000020 deadbeef", gnt, mem_we, mem_a, mem_wd);
        end
        next_cycle();
        we = 2'b00; addr0 = 32'h22;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b01 || mem_we !== 1'b0 || mem_a !== 32'h20) begin
            miscompares++;
            $display("FAIL full_rd: gnt=%b we=%b A=%h, expected 01 0 00000020", gnt, mem_we, mem_a);
        end
        exp_port.push_back(0); exp_data.push_back(32'hDEAD_BEEF);
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_zero_be();
        req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'h1234_5678; be0 = 4'h0;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b01 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_be_gnt: gnt=%b we=%b, expected 01 0", gnt, mem_we);
        end
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        vectors++;
        if (rvalid !== 2'b00 || mem[8] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL zero_be_noop: rvalid=%b mem[0x20]=%h, expected 00 deadbeef", rvalid, mem[8]);
        end
        next_cycle();
    endtask

    task automatic test_partial_write();
        poke_en = 1'b1; poke_idx = 6'd16; poke_val = 32'h1122_3344;
        next_cycle();
        poke_en = 1'b0;
        req = 2'b10; we = 2'b10; addr1 = 32'h40; wdata1 = 32'hAABB_CCDD; be1 = 4'b0101;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b10 || mem_we !== 1'b0 || mem_a !== 32'h40) begin
            miscompares++;
            $display("FAIL rmw_rd: gnt=%b we=%b A=%h, expected 10 0 00000040", gnt, mem_we, mem_a);
        end
        next_cycle();
        we = 2'b00;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b00 || mem_we !== 1'b1 || mem_a !== 32'h40 || mem_wd !== 32'h11BB_33DD) begin
            miscompares++;
            $display("FAIL rmw_wr: gnt=%b we=%b A=%h WD=%h, expected 00 1 00000040 11bb33dd", gnt, mem_we, mem_a, mem_wd);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b10) begin
            miscompares++;
            $display("FAIL rmw_next_rd: gnt=%b, expected 10", gnt);
        end
        exp_port.push_back(1); exp_data.push_back(32'h11BB_33DD);
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_contention();
        req = 2'b11; we = 2'b00; addr0 = 32'h20; addr1 = 32'h40;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL contention%0d: gnt=%b, expected %b", i, gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            exp_port.push_back(i % 2);
            exp_data.push_back((i % 2 == 0) ? 32'hDEAD_BEEF : 32'h11BB_33DD);
            next_cycle();
        end
        req = 2'b00;
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        req = 2'b11; we = 2'b01;
        addr0 = 32'h24; wdata0 = 32'h0000_00AB; be0 = 4'b0001;
        addr1 = 32'h20;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b01 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_n: gnt=%b we=%b, expected 01 0", gnt, mem_we);
        end
        next_cycle();
        req = 2'b10;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b00 || mem_we !== 1'b1 || mem_a !== 32'h24 || mem_wd !== 32'hFFFF_FFAB) begin
            miscompares++;
            $display("FAIL b2b_n1: gnt=%b we=%b A=%h WD=%h, expected 00 1 00000024 ffffffab", gnt, mem_we, mem_a, mem_wd);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_n2: gnt=%b, expected 10", gnt);
        end
        exp_port.push_back(1); exp_data.push_back(32'hDEAD_BEEF);
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_reset_mid_rmw();
        req = 2'b01; we = 2'b01; addr0 = 32'h40; wdata0 = 32'h5500_0000; be0 = 4'b1000;
        @(negedge clk);
        vectors++;
        if (gnt !== 2'b01 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_gnt: gnt=%b we=%b, expected 01 0", gnt, mem_we);
        end
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        vectors++;
        if (mem_we !== 1'b1 || mem_wd !== 32'h55BB_33DD) begin
            miscompares++;
            $display("FAIL abort_pre: we=%b WD=%h, expected 1 55bb33dd", mem_we, mem_wd);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (mem_we !== 1'b0 || mem_a !== 32'h0 || init_done !== 1'b0 || gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_async: we=%b A=%h done=%b gnt=%b, expected 0 0 0 00", mem_we, mem_a, init_done, gnt);
        end
        next_cycle();
        vectors++;
        if (mem[16] !== 32'h11BB_33DD) begin
            miscompares++;
            $display("FAIL abort_word: mem[0x40]=%h, expected 11bb33dd", mem[16]);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_we !== 1'b1 || mem_a !== 32'h0 || mem_wd !== 32'h0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_restart: we=%b A=%h WD=%h done=%b, expected 1 0 0 0", mem_we, mem_a, mem_wd, init_done);
        end
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk);
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_done: done=%b, expected 1", init_done);
        end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_write_read();
        test_zero_be();
        test_partial_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_rmw();
        vectors++;
        if (exp_data.size() != 0) begin
            miscompares++;
            $display("FAIL rd_missing: %0d read responses outstanding, expected 0", exp_data.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller between the MIPS core's load/store unit, a debug/DMA port and the single-port `data_mem` array. It arbitrates the two requesters round-robin and implements sub-word stores as read-modify-write sequences. After reset it zero-fills a configurable memory region before granting any request. It replaces the array's in-loop reset with a sequenced clear.

## Interface
- `P_CLR_WORDS`, 256: number of 32-bit words zeroed after reset, starting at address 0; must be ≥1.
- `i_clk` in 1: clock, all state on rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_req[1:0]` in 2: request per port; port 0 = LSU, port 1 = debug/DMA.
- `i_we[1:0]` in 2: per-port write (1) / read (0).
- `i_addr0`, `i_addr1` in 32: byte address; bits [1:0] ignored (word aligned).
- `i_wdata0`, `i_wdata1` in 32: write data.
- `i_be0`, `i_be1` in 4: byte enables; bit k covers bits [8k+7:8k].
- `o_gnt[1:0]` out 2: one-cycle accept pulse per port.
- `o_rvalid[1:0]` out 2: read data valid, one cycle.
- `o_rdata` out 32: registered read word, shared by both ports.
- `o_mem_A` out 32: address to the array, always `{addr[31:2],2'b00}`.
- `o_mem_WD` out 32: write data to the array.
- `o_mem_WE` out 1: write enable to the array.
- `i_mem_RD` in 32: combinational read data from the array.
- `o_init_done` out 1: high once the clear sequence completes.

## Operation
- FSM states: CLEAR, IDLE, RMW_WR. On reset the FSM enters CLEAR.
- CLEAR:
  - Counter `clr_idx` counts 0..P_CLR_WORDS-1.
  - Each cycle drives `o_mem_A=clr_idx*4`, `o_mem_WD=0`, `o_mem_WE=1`.
  - After the last index, the FSM moves to IDLE and sets `o_init_done`, which stays high until the next reset.
  - No grants are issued in CLEAR; requesters keep `i_req` asserted.
- IDLE arbitration:
  - Register `last` resets to 1.
  - If exactly one port requests, that port wins.
  - If both ports request, the port ≠ `last` wins.
  - `last` updates on every grant.
  - The winner's address and control drive the array combinationally, and `o_gnt[w]` pulses in the same cycle.
- Read in IDLE: `o_rdata<=i_mem_RD` at the edge; `o_rvalid[w]=1` in the next cycle.
- Write with be=4'hF: `o_mem_WE=1`, `o_mem_WD=wdata`; completes in one cycle.
- Write with be=4'h0: granted as a no-op. No memory write and no `o_rvalid`.
- Write with a partial be:
  - Grant cycle is the read phase (`o_mem_WE=0`).
  - At the edge, latch the address, wdata, be and `i_mem_RD`, then move to RMW_WR.
- RMW_WR:
  - Drive the latched address with `o_mem_WE=1`.
  - For each byte, `o_mem_WD` takes wdata where be=1, else the latched old byte.
  - No grant this cycle; return to IDLE.
- Reset mid-operation aborts any RMW (the pending write is lost), clears `o_init_done` and restarts CLEAR from index 0.

## Timing
- Reset values:
  - `o_gnt=0`, `o_rvalid=0`, `o_rdata=0`, `o_init_done=0`.
  - `o_mem_WE=0`, `o_mem_A=0`, `o_mem_WD=0`.
  - `last=1`, `clr_idx=0`.
  - The first cycle after reset release is CLEAR idx 0.
- CLEAR takes exactly P_CLR_WORDS cycles. `o_init_done` rises in the cycle after the last clear write.
- Read latency is 1 cycle from grant to `o_rvalid`.
- Full write takes 1 cycle; partial write takes 2 cycles and occupies the array for both.
- Back-to-back grants are possible every cycle in IDLE, but not in the cycle after a partial-write grant.
- A read granted immediately after RMW_WR returns the merged data.
- Requests are level signals; a port that is not granted holds its address, data and be stable until `o_gnt`.
- Contention: two continuous requesters alternate grants 0,1,0,1.

## Structure
- Package `dmem_pkg`:
  - `typedef enum logic [1:0] {CLEAR, IDLE, RMW_WR} dmem_state_t`.
  - Port index constants `PORT_LSU=0`, `PORT_DBG=1`.
  - Merge function `be_merge(old, new, be)`.
- Sub-module `rr_arb2`: 2-input round-robin arbiter with the `last` register, grant vector output and an enable input tied to the IDLE state.
- All else lives in `dmem_ctrl`; size ≈150–250 lines.

## Test plan
- Reset with P_CLR_WORDS=4 and the array preloaded with 0xFFFFFFFF: expect writes of 0 to addresses 0,4,8,12 in cycles 0–3, `o_init_done=1` in cycle 4, and `i_req=2'b11` held throughout with no `o_gnt` before then.
- Port 0 writes 0xDEADBEEF at 0x20 with be=F, then reads 0x20: `o_gnt` on each request and `o_rdata=0xDEADBEEF` with `o_rvalid[0]` one cycle after the read grant.
- Word 0x11223344 at 0x40; port 1 writes 0xAABBCCDD with be=4'b0101: two-cycle sequence, no grant in cycle 2, and a subsequent read returns 0x11BB33DD.
- Both ports requesting reads continuously for 6 cycles: grant order 0,1,0,1,0,1.
- Port 0 partial write while port 1 requests: grants are port 0 (cycle N), none (N+1), port 1 (N+2).
- Assert `i_rst` during RMW_WR: `o_mem_WE` drops asynchronously, the target word is unchanged, and the clear restarts at address 0.
